// File: rtl/count_checker_pkg.sv
// rtl/count_checker_pkg.sv - shared types and default widths for count_checker
// Holds the checker FSM state enum and the default WIDTH / ERR_W values.
package count_checker_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ERR_W = 16;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOCKED = 2'd1,
        FAIL   = 2'd2
    } state_t;

endpackage

// File: rtl/count_checker_if.sv
// rtl/count_checker_if.sv - sample stream interface feeding count_checker
// Signals: valid_i (sample present), value_i (observed count), max_i (wrap bound).
// master drives the stream, slave (the checker) consumes it.
interface count_checker_if
    import count_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             valid_i;
    logic [WIDTH-1:0] value_i;
    logic [WIDTH-1:0] max_i;

    modport master (output valid_i, output value_i, output max_i);
    modport slave  (input  valid_i, input  value_i, input  max_i);

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter
// Ports: clk, rst (sync active-high), inc (count request), count (value, sticks at all-ones).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/count_checker.sv
// rtl/count_checker.sv - checks a 0..max wrapping counter stream
// Ports: clk_i, rst_i (sync active-high), smp (slave stream: valid_i/value_i/max_i),
//        locked_o, mismatch_o, expected_o, err_count_o, wraps_o (all registered).
// Macro COUNT_CHECKER_RESYNC_EN: when defined a mismatch returns to SYNC,
// otherwise the checker parks in FAIL until reset.
module count_checker
    import count_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERR_W = DEF_ERR_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    count_checker_if.slave   smp,
    output logic             locked_o,
    output logic             mismatch_o,
    output logic [WIDTH-1:0] expected_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic [ERR_W-1:0] wraps_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic             mismatch_q, mismatch_d;
    logic             locked_q;
    logic             err_inc;
    logic             wrap_inc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= SYNC;
            exp_q      <= '0;
            max_q      <= '0;
            mismatch_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            max_q      <= max_d;
            mismatch_q <= mismatch_d;
            locked_q   <= (state_d == LOCKED);
        end
    end

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        max_d      = max_q;
        mismatch_d = 1'b0;
        err_inc    = 1'b0;
        wrap_inc   = 1'b0;
        case (state_q)
            SYNC: begin
                // Only a 0 can start the sequence; the bound is frozen here.
                if (smp.valid_i && (smp.value_i == '0)) begin
                    state_d = LOCKED;
                    max_d   = smp.max_i;
                    exp_d   = (smp.max_i == '0) ? '0 : ONE;
                end
            end
            LOCKED: begin
                if (smp.valid_i) begin
                    if (smp.value_i == exp_q) begin
                        // A correct sample at the bound is a completed wrap.
                        wrap_inc = (smp.value_i == max_q);
                        exp_d    = (exp_q == max_q) ? '0 : exp_q + ONE;
                    end else begin
                        mismatch_d = 1'b1;
                        err_inc    = 1'b1;
`ifdef COUNT_CHECKER_RESYNC_EN
                        state_d    = SYNC;
`else
                        state_d    = FAIL;
`endif
                    end
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (err_inc),
        .count (err_count_o)
    );

    sat_counter #(.W(ERR_W)) u_wrap_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (wrap_inc),
        .count (wraps_o)
    );

    assign locked_o   = locked_q;
    assign mismatch_o = mismatch_q;
    assign expected_o = exp_q;

endmodule

// File: tb/tb_count_checker.sv
// tb/tb_count_checker.sv - self-checking bench for count_checker
module tb_count_checker;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    always #5 clk = ~clk;

    count_checker_if #(.WIDTH(8)) if_a ();
    count_checker_if #(.WIDTH(8)) if_b ();

    logic        locked_a, mis_a;
    logic [7:0]  exp_a;
    logic [15:0] err_a, wraps_a;

    logic        locked_b, mis_b;
    logic [7:0]  exp_b;
    logic [1:0]  err_b, wraps_b;

    count_checker #(.WIDTH(8), .ERR_W(16)) dut_a (
        .clk_i       (clk),
        .rst_i       (rst_a),
        .smp         (if_a.slave),
        .locked_o    (locked_a),
        .mismatch_o  (mis_a),
        .expected_o  (exp_a),
        .err_count_o (err_a),
        .wraps_o     (wraps_a)
    );

    count_checker #(.WIDTH(8), .ERR_W(2)) dut_b (
        .clk_i       (clk),
        .rst_i       (rst_b),
        .smp         (if_b.slave),
        .locked_o    (locked_b),
        .mismatch_o  (mis_b),
        .expected_o  (exp_b),
        .err_count_o (err_b),
        .wraps_o     (wraps_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: sequence tracker written in plain integers.
    bit m_locked, m_failed, m_mis;
    int m_exp, m_max, m_err, m_wrap;
    localparam int SAT16 = 65535;

    task automatic model_reset();
        m_locked = 0; m_failed = 0; m_mis = 0;
        m_exp = 0; m_max = 0; m_err = 0; m_wrap = 0;
    endtask

    task automatic model_step(input bit v, input int val, input int mx);
        m_mis = 0;
        if (v && !m_failed) begin
            if (!m_locked) begin
                if (val == 0) begin
                    m_locked = 1;
                    m_max    = mx;
                    m_exp    = (mx == 0) ? 0 : 1;
                end
            end else if (val == m_exp) begin
                if (val == m_max) m_wrap = (m_wrap < SAT16) ? m_wrap + 1 : SAT16;
                m_exp = (m_exp + 1) % (m_max + 1);
            end else begin
                m_mis    = 1;
                m_err    = (m_err < SAT16) ? m_err + 1 : SAT16;
                m_locked = 0;
`ifndef COUNT_CHECKER_RESYNC_EN
                m_failed = 1;
`endif
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag);
        chk({tag, "_locked"}, 32'(locked_a), 32'(m_locked));
        chk({tag, "_mismatch"}, 32'(mis_a), 32'(m_mis));
        chk({tag, "_expected"}, 32'(exp_a), 32'(m_exp));
        chk({tag, "_err"}, 32'(err_a), 32'(m_err));
        chk({tag, "_wraps"}, 32'(wraps_a), 32'(m_wrap));
    endtask

    task automatic step_a(input string tag, input bit v, input int val, input int mx);
        @(negedge clk);
        rst_a        = 1'b0;
        if_a.valid_i = v;
        if_a.value_i = val[7:0];
        if_a.max_i   = mx[7:0];
        @(posedge clk);
        model_step(v, val, mx);
        #1;
        check_a(tag);
    endtask

    task automatic reset_a(input string tag, input bit v, input int val);
        @(negedge clk);
        rst_a        = 1'b1;
        if_a.valid_i = v;
        if_a.value_i = val[7:0];
        @(posedge clk);
        model_reset();
        #1;
        check_a(tag);
    endtask

    task automatic step_b(input bit r, input bit v, input int val);
        @(negedge clk);
        rst_b        = r;
        if_b.valid_i = v;
        if_b.value_i = val[7:0];
        if_b.max_i   = 8'd0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s1_exp[5];
        int s1_val[5];
        int val, mx, r;
        bit v;
        s1_exp = '{1, 2, 0, 1, 2};
        s1_val = '{0, 1, 2, 0, 1};
        if_a.valid_i = 0; if_a.value_i = '0; if_a.max_i = '0;
        if_b.valid_i = 0; if_b.value_i = '0; if_b.max_i = '0;
        model_reset();

        // Lock scenario
        reset_a("rst0", 0, 0);
        reset_a("rst1", 0, 0);
        for (int i = 0; i < 5; i++) begin
            step_a("lock", 1, s1_val[i], 2);
            chk("lock_exp_const", 32'(exp_a), 32'(s1_exp[i]));
            chk("lock_locked_const", 32'(locked_a), 32'd1);
        end
        chk("lock_wraps_const", 32'(wraps_a), 32'd1);

        // Mismatch scenario
        reset_a("rst_mm", 0, 0);
        step_a("mm", 1, 0, 3);
        step_a("mm", 1, 1, 3);
        step_a("mm_bad", 1, 3, 3);
        chk("mm_pulse_const", 32'(mis_a), 32'd1);
        chk("mm_err_const", 32'(err_a), 32'd1);
        chk("mm_locked_const", 32'(locked_a), 32'd0);
        step_a("mm_after", 0, 0, 3);
        chk("mm_pulse_end", 32'(mis_a), 32'd0);
`ifdef COUNT_CHECKER_RESYNC_EN
        step_a("resync", 1, 2, 3);
        chk("resync_ignored", 32'(locked_a), 32'd0);
        step_a("resync", 1, 0, 3);
        chk("resync_lock", 32'(locked_a), 32'd1);
        step_a("resync", 1, 1, 3);
        chk("resync_exp", 32'(exp_a), 32'd2);
        chk("resync_err", 32'(err_a), 32'd1);
`else
        step_a("hold", 1, 0, 3);
        step_a("hold", 1, 1, 3);
        step_a("hold", 1, 2, 3);
        chk("hold_locked", 32'(locked_a), 32'd0);
        chk("hold_err", 32'(err_a), 32'd1);
`endif
        reset_a("rst_hold", 1, 0);
        chk("rst_hold_err", 32'(err_a), 32'd0);

        // Gaps and a bound change while locked
        step_a("gap", 1, 0, 2);
        step_a("gap", 0, 0, 2);
        step_a("gap", 0, 0, 2);
        step_a("gap", 1, 1, 2);
        step_a("gap", 1, 2, 5);
        step_a("gap", 1, 0, 5);
        chk("gap_wraps", 32'(wraps_a), 32'd1);
        chk("gap_mis", 32'(mis_a), 32'd0);

        // Randomised stream, mostly legal with occasional faults and resets
        for (int i = 0; i < 600; i++) begin
            r  = $urandom_range(0, 99);
            v  = ($urandom_range(0, 3) != 0);
            mx = $urandom_range(0, 6);
            if (!m_locked) val = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(0, 7);
            else if (r < 90) val = m_exp;
            else val = $urandom_range(0, 7);
            if (r < 3) reset_a("rnd_rst", v, val);
            else step_a("rnd", v, val, mx);
        end

        // Saturation with ERR_W = 2 and max = 0
        step_b(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step_b(0, 1, 0);
            chk("sat_wraps", 32'(wraps_b), 32'((i < 3) ? i : 3));
            chk("sat_locked", 32'(locked_b), 32'd1);
        end
        step_b(1, 1, 0);
        chk("sat_rst_wraps", 32'(wraps_b), 32'd0);
        chk("sat_rst_locked", 32'(locked_b), 32'd0);
        chk("sat_rst_exp", 32'(exp_b), 32'd0);
        chk("sat_rst_err", 32'(err_b), 32'd0);
        chk("sat_rst_mis", 32'(mis_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
